// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the fetch/data memory arbiter.
// The arbiter connects through the slave modport. The requesters and memory model connect
// through the master modport.
interface mem_arbiter_if;
    // Fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    // Load/store requester
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        err;
    // Shared memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for one shared memory port.
// A transaction goes through IDLE -> BUS -> RESP. A tie goes to the requester that was not
// granted last. A BUS phase that sees no mem_ack within TIMEOUT cycles ends with err set.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        gnt_d_q;   // current grant belongs to the data requester
    logic        last_d_q;  // most recent grant went to the data requester
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_valid_q;
    logic        d_valid_q;
    logic        err_q;

    logic        pick_d;
    logic [31:0] term_rdata;

    // Grant choice in IDLE, and the data returned when BUS terminates (zero on timeout).
    always_comb begin
        pick_d     = bus_io.d_req & (~bus_io.if_req | ~last_d_q);
        term_rdata = bus_io.mem_ack ? bus_io.mem_rdata : 32'h0;
    end

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_d_q     <= 1'b0;
            last_d_q    <= 1'b1;  // first tie goes to fetch
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Valid and err are single-cycle pulses.
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.if_req || bus_io.d_req) begin
                        gnt_d_q   <= pick_d;
                        last_d_q  <= pick_d;
                        cnt_q     <= 8'd0;
                        mem_req_q <= 1'b1;
                        state_q   <= StBus;
                        if (pick_d) begin
                            mem_addr_q  <= bus_io.d_addr;
                            mem_we_q    <= bus_io.d_we;
                            mem_wdata_q <= bus_io.d_wdata;
                            mem_wstrb_q <= bus_io.d_we ? bus_io.d_wstrb : 4'h0;
                        end else begin
                            mem_addr_q  <= bus_io.if_addr;
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= 32'h0;
                            mem_wstrb_q <= 4'h0;
                        end
                    end
                end
                StBus: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (bus_io.mem_ack || (cnt_q == CntLast)) begin
                        if (gnt_d_q) begin
                            d_rdata_q <= term_rdata;
                        end else begin
                            if_rdata_q <= term_rdata;
                        end
                        if_valid_q <= ~gnt_d_q;
                        d_valid_q  <= gnt_d_q;
                        err_q      <= ~bus_io.mem_ack;
                        mem_req_q  <= 1'b0;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.mem_req   = mem_req_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_wdata = mem_wdata_q;
    assign bus_io.mem_wstrb = mem_wstrb_q;
    assign bus_io.if_rdata  = if_rdata_q;
    assign bus_io.if_valid  = if_valid_q;
    assign bus_io.d_rdata   = d_rdata_q;
    assign bus_io.d_valid   = d_valid_q;
    assign bus_io.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. The bench plays both requesters and the memory. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_arbiter;
    localparam int TO = 4;

    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: who was granted last, and the rdata each side should be holding.
    bit          last_is_d;
    logic [31:0] hold_if;
    logic [31:0] hold_d;

    typedef struct packed {
        logic        timed_out;
        int          req_lat;
        int          bus_cycles;
        logic        stable;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        ifv;
        logic        dv;
        logic        err;
        logic [31:0] if_rd;
        logic [31:0] d_rd;
        logic        valid_after;
        logic [31:0] if_hold;
        logic [31:0] d_hold;
    } txn_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Memory responder and observer. It acks in BUS cycle ack_delay+1, or never if
    // ack_delay < 0. It returns at the IDLE negedge after the response.
    task automatic serve(input int ack_delay, input logic [31:0] rd, output txn_t o);
        int n;
        o = '0;
        o.timed_out = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 16);
        o.req_lat = n;
        if (!bus.mem_req) return;
        o.addr = bus.mem_addr;
        o.we = bus.mem_we;
        o.wdata = bus.mem_wdata;
        o.wstrb = bus.mem_wstrb;
        o.stable = 1'b1;
        n = 0;
        while (bus.mem_req && n < 64) begin
            n++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !==
                {o.addr, o.we, o.wdata, o.wstrb}) o.stable = 1'b0;
            if (ack_delay >= 0 && n == ack_delay + 1) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd;
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = $urandom;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        o.bus_cycles = n;
        if (bus.mem_req) return;
        o.ifv = bus.if_valid;
        o.dv = bus.d_valid;
        o.err = bus.err;
        o.if_rd = bus.if_rdata;
        o.d_rd = bus.d_rdata;
        if (bus.if_valid) bus.if_req = 1'b0;
        if (bus.d_valid) bus.d_req = 1'b0;
        @(negedge clk);
        o.valid_after = bus.if_valid | bus.d_valid | bus.err;
        o.if_hold = bus.if_rdata;
        o.d_hold = bus.d_rdata;
        o.timed_out = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_is_d = 1'b1;
        hold_if = 32'h0;
        hold_d = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 1'b1;
        bus.d_req = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 70'h0) begin
            n_bad++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h wstrb=%h want all zero",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        n_cmp++;
        if ({bus.if_valid, bus.d_valid, bus.err, bus.if_rdata, bus.d_rdata} !== 67'h0) begin
            n_bad++;
            $display("FAIL reset_resp: got ifv=%b dv=%b err=%b if_rdata=%h d_rdata=%h want all zero",
                     bus.if_valid, bus.d_valid, bus.err, bus.if_rdata, bus.d_rdata);
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        bus.mem_ack = 1'b0;
        rst = 1'b0;
        last_is_d = 1'b1;
        hold_if = 32'h0;
        hold_d = 32'h0;
    endtask

    task automatic test_fetch();
        txn_t o;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        serve(2, 32'h00500093, o);
        n_cmp++;
        if ({o.timed_out, o.req_lat, o.bus_cycles} !== {1'b0, 32'sd1, 32'sd3}) begin
            n_bad++;
            $display("FAIL fetch_timing: got to=%b req_lat=%0d bus=%0d want to=0 req_lat=1 bus=3",
                     o.timed_out, o.req_lat, o.bus_cycles);
        end
        n_cmp++;
        if ({o.stable, o.addr, o.we, o.wstrb, o.wdata} !== {1'b1, 32'h100, 1'b0, 4'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL fetch_bus: got st=%b addr=%h we=%b wstrb=%h wdata=%h want 1 100 0 0 0",
                     o.stable, o.addr, o.we, o.wstrb, o.wdata);
        end
        n_cmp++;
        if ({o.ifv, o.dv, o.err, o.if_rd} !== {3'b100, 32'h00500093}) begin
            n_bad++;
            $display("FAIL fetch_resp: got ifv=%b dv=%b err=%b rdata=%h want 1 0 0 00500093",
                     o.ifv, o.dv, o.err, o.if_rd);
        end
        n_cmp++;
        if ({o.valid_after, o.if_hold} !== {1'b0, 32'h00500093}) begin
            n_bad++;
            $display("FAIL fetch_hold: got pulse_after=%b if_rdata=%h want 0 00500093",
                     o.valid_after, o.if_hold);
        end
        last_is_d = 1'b0;
        hold_if = 32'h00500093;
    endtask

    // A store issued in the IDLE cycle right after a valid must be granted straight away.
    task automatic test_back_to_back();
        txn_t o;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h0000_0400;
        bus.d_wdata = 32'hA5A5_0F0F;
        bus.d_wstrb = 4'h3;
        serve(0, 32'h7777_1111, o);
        n_cmp++;
        if ({o.timed_out, o.req_lat, o.bus_cycles} !== {1'b0, 32'sd1, 32'sd1}) begin
            n_bad++;
            $display("FAIL b2b_timing: got to=%b req_lat=%0d bus=%0d want to=0 req_lat=1 bus=1",
                     o.timed_out, o.req_lat, o.bus_cycles);
        end
        n_cmp++;
        if ({o.addr, o.we, o.wstrb, o.wdata, o.ifv, o.dv, o.err, o.d_rd} !==
            {32'h400, 1'b1, 4'h3, 32'hA5A50F0F, 3'b010, 32'h77771111}) begin
            n_bad++;
            $display("FAIL b2b_store: got addr=%h we=%b wstrb=%h wdata=%h v=%b%b err=%b rd=%h",
                     o.addr, o.we, o.wstrb, o.wdata, o.ifv, o.dv, o.err, o.d_rd);
        end
        n_cmp++;
        if ({o.valid_after, o.if_hold, o.d_hold} !== {1'b0, hold_if, 32'h77771111}) begin
            n_bad++;
            $display("FAIL b2b_hold: got pulse_after=%b if=%h d=%h want 0 %h 77771111",
                     o.valid_after, o.if_hold, o.d_hold, hold_if);
        end
    endtask

    task automatic test_tie();
        txn_t o;
        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_0200;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_wstrb = 4'hF;
        serve(0, 32'h1111_2222, o);
        n_cmp++;
        if ({o.timed_out, o.ifv, o.dv, o.addr, o.we} !== {3'b010, 32'h200, 1'b0}) begin
            n_bad++;
            $display("FAIL tie_first: got to=%b v=%b%b addr=%h we=%b want fetch of 00000200",
                     o.timed_out, o.ifv, o.dv, o.addr, o.we);
        end
        serve(1, 32'h3333_4444, o);
        n_cmp++;
        if ({o.timed_out, o.req_lat, o.ifv, o.dv, o.err} !== {1'b0, 32'sd1, 3'b010}) begin
            n_bad++;
            $display("FAIL tie_second: got to=%b req_lat=%0d v=%b%b err=%b want d_valid",
                     o.timed_out, o.req_lat, o.ifv, o.dv, o.err);
        end
        n_cmp++;
        if ({o.addr, o.we, o.wdata, o.wstrb, o.d_rd} !==
            {32'h2000, 1'b1, 32'hDEADBEEF, 4'hF, 32'h33334444}) begin
            n_bad++;
            $display("FAIL tie_store: got addr=%h we=%b wdata=%h wstrb=%h rd=%h",
                     o.addr, o.we, o.wdata, o.wstrb, o.d_rd);
        end
        bus.if_req = 1'b1;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        serve(0, 32'h5555_6666, o);
        n_cmp++;
        if ({o.timed_out, o.ifv, o.dv, o.if_rd} !== {3'b010, 32'h55556666}) begin
            n_bad++;
            $display("FAIL tie_third: got to=%b v=%b%b rd=%h want fetch 55556666",
                     o.timed_out, o.ifv, o.dv, o.if_rd);
        end
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
    endtask

    task automatic test_alternate();
        txn_t o;
        logic exp_d;
        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_0800;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0000_9000;
        for (int i = 0; i < 6; i++) begin
            exp_d = !last_is_d;
            serve(i % 3, $urandom, o);
            n_cmp++;
            if ({o.timed_out, o.ifv, o.dv} !== {1'b0, !exp_d, exp_d}) begin
                n_bad++;
                $display("FAIL alt_grant%0d: got to=%b ifv=%b dv=%b want ifv=%b dv=%b",
                         i, o.timed_out, o.ifv, o.dv, !exp_d, exp_d);
            end
            last_is_d = exp_d;
            if (exp_d) bus.d_req = 1'b1;
            else bus.if_req = 1'b1;
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic test_timeout();
        txn_t o;
        do_reset();
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0000_3000;
        serve(-1, 32'h0, o);
        n_cmp++;
        if ({o.timed_out, o.bus_cycles} !== {1'b0, TO}) begin
            n_bad++;
            $display("FAIL timeout_len: got to=%b bus=%0d want to=0 bus=%0d",
                     o.timed_out, o.bus_cycles, TO);
        end
        n_cmp++;
        if ({o.ifv, o.dv, o.err, o.d_rd} !== {3'b011, 32'h0}) begin
            n_bad++;
            $display("FAIL timeout_resp: got ifv=%b dv=%b err=%b rd=%h want 0 1 1 0",
                     o.ifv, o.dv, o.err, o.d_rd);
        end
        n_cmp++;
        if ({o.valid_after, o.d_hold} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL timeout_after: got pulse_after=%b d_rdata=%h want 0 0",
                     o.valid_after, o.d_hold);
        end
    endtask

    task automatic test_ack_at_timeout();
        txn_t o;
        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_0040;
        serve(TO - 1, 32'h12345678, o);
        n_cmp++;
        if ({o.timed_out, o.bus_cycles, o.ifv, o.dv, o.err, o.if_rd} !==
            {1'b0, TO, 3'b100, 32'h12345678}) begin
            n_bad++;
            $display("FAIL ack_at_timeout: got to=%b bus=%0d v=%b%b err=%b rd=%h want bus=%0d 1 0 0 12345678",
                     o.timed_out, o.bus_cycles, o.ifv, o.dv, o.err, o.if_rd, TO);
        end
    endtask

    task automatic test_reset_in_bus();
        txn_t o;
        logic seen;
        do_reset();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_0600;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rstbus_start: got mem_req=%b want 1", bus.mem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.if_req = 1'b0;
        last_is_d = 1'b1;
        hold_if = 32'h0;
        hold_d = 32'h0;
        n_cmp++;
        if ({bus.mem_req, bus.if_valid, bus.d_valid, bus.err} !== 4'b0) begin
            n_bad++;
            $display("FAIL rstbus_abort: got req=%b ifv=%b dv=%b err=%b want 0 0 0 0",
                     bus.mem_req, bus.if_valid, bus.d_valid, bus.err);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.mem_req | bus.if_valid | bus.d_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rstbus_quiet: got activity=%b want 0", seen);
        end
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0000_5000;
        serve(1, 32'hCAFE_F00D, o);
        n_cmp++;
        if ({o.timed_out, o.req_lat, o.bus_cycles, o.addr, o.ifv, o.dv, o.err, o.d_rd} !==
            {1'b0, 32'sd1, 32'sd2, 32'h5000, 3'b010, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL rstbus_next: got to=%b lat=%0d bus=%0d addr=%h v=%b%b err=%b rd=%h",
                     o.timed_out, o.req_lat, o.bus_cycles, o.addr, o.ifv, o.dv, o.err, o.d_rd);
        end
    endtask

    // Random mix of pending requests, ack delays (including timeouts) and store/load.
    task automatic test_random();
        txn_t o;
        bit pi, pd, g_d, ee, dwe;
        logic [31:0] ia, da, dw, rd, erd;
        logic [3:0] ds;
        int dly, eb;
        do_reset();
        pi = 1'b0;
        pd = 1'b0;
        ia = 32'h0;
        da = 32'h0;
        dw = 32'h0;
        ds = 4'h0;
        dwe = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1'b1;
                ia = $urandom;
            end
            if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
                pd = 1'b1;
                da = $urandom;
                dw = $urandom;
                ds = 4'($urandom);
                dwe = 1'($urandom_range(0, 1));
            end
            bus.if_req = pi;
            bus.if_addr = ia;
            bus.d_req = pd;
            bus.d_addr = da;
            bus.d_we = dwe;
            bus.d_wdata = dw;
            bus.d_wstrb = ds;
            g_d = pd && (!pi || !last_is_d);
            last_is_d = g_d;
            dly = $urandom_range(0, 5);
            rd = $urandom;
            ee = (dly >= TO);
            eb = ee ? TO : dly + 1;
            erd = ee ? 32'h0 : rd;
            if (g_d) hold_d = erd;
            else hold_if = erd;
            serve(dly, rd, o);
            n_cmp++;
            if ({o.timed_out, o.req_lat, o.bus_cycles, o.stable} !== {1'b0, 32'sd1, eb, 1'b1}) begin
                n_bad++;
                $display("FAIL rnd%0d_timing: got to=%b lat=%0d bus=%0d st=%b want 0 1 %0d 1",
                         k, o.timed_out, o.req_lat, o.bus_cycles, o.stable, eb);
            end
            n_cmp++;
            if ({o.addr, o.we, o.wstrb} !== (g_d ? {da, dwe, dwe ? ds : 4'h0} : {ia, 1'b0, 4'h0})) begin
                n_bad++;
                $display("FAIL rnd%0d_bus: got addr=%h we=%b wstrb=%h want grant_d=%b",
                         k, o.addr, o.we, o.wstrb, g_d);
            end
            if (!g_d || dwe) begin
                n_cmp++;
                if (o.wdata !== (g_d ? dw : 32'h0)) begin
                    n_bad++;
                    $display("FAIL rnd%0d_wdata: got %h want %h", k, o.wdata, g_d ? dw : 32'h0);
                end
            end
            n_cmp++;
            if ({o.ifv, o.dv, o.err, (g_d ? o.d_rd : o.if_rd)} !== {!g_d, g_d, ee, erd}) begin
                n_bad++;
                $display("FAIL rnd%0d_resp: got ifv=%b dv=%b err=%b rd=%h want %b %b %b %h",
                         k, o.ifv, o.dv, o.err, g_d ? o.d_rd : o.if_rd, !g_d, g_d, ee, erd);
            end
            n_cmp++;
            if ({o.valid_after, o.if_hold, o.d_hold} !== {1'b0, hold_if, hold_d}) begin
                n_bad++;
                $display("FAIL rnd%0d_hold: got pulse_after=%b if=%h d=%h want 0 %h %h",
                         k, o.valid_after, o.if_hold, o.d_hold, hold_if, hold_d);
            end
            if (g_d) pd = 1'b0;
            else pi = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_wstrb = 4'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack = 1'b0;
        last_is_d = 1'b1;
        hold_if = 32'h0;
        hold_d = 32'h0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_tie();
        test_alternate();
        test_timeout();
        test_ack_at_timeout();
        test_reset_in_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
